// File: rtl/lcd_writer.sv
// lcd_writer: 32-character frame buffer that pushes its contents to a
// two-row character LCD driver as a fixed 34-word refresh sequence
// (row-0 address, 16 chars, row-1 address, 16 chars).
module lcd_writer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh,
  input  logic       busy_flag,
  output logic [8:0] d_out,
  output logic       data_ready,
  output logic       active,
  output logic       done
);

  localparam int unsigned TMO_BITS =
    ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [5:0] LAST_IDX = 6'd33;
  localparam logic [5:0] ROW1_IDX = 6'd17;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [5:0]          idx;
  logic [TMO_BITS-1:0] tmo;
  logic [TMO_BITS-1:0] tmo_inc;
  logic                pending;
  logic [7:0]          frame [32];
  logic [4:0]          char_addr;
  logic [8:0]          word;
  logic [8:0]          d_hold;
  logic                done_r;

  assign tmo_inc = tmo + 1'b1;

  // Frame buffer: cleared to spaces on reset, otherwise written on wr_en.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        frame[i] <= 8'h20;
      end
    end else if (wr_en) begin
      frame[wr_addr] <= wr_char;
    end
  end

  // Pending request flag; a new request in the same cycle as the IDLE clear wins.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      pending <= 1'b1;
    end else if (refresh || wr_en) begin
      pending <= 1'b1;
    end else if (state == IDLE && pending) begin
      pending <= 1'b0;
    end
  end

  // Transfer word for the current index, read straight from the buffer.
  always_comb begin
    char_addr = (idx < ROW1_IDX) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
    word      = {1'b1, frame[char_addr]};
    if (idx == 6'd0) begin
      word = 9'h080;
    end else if (idx == ROW1_IDX) begin
      word = 9'h0C0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (pending) state_next = WAIT_READY;
      WAIT_READY: if (!busy_flag) state_next = ISSUE;
      ISSUE:      state_next = WAIT_ACK;
      // The counter counts WAIT_ACK cycles, so a missing ack re-pulses
      // data_ready every ACK_TIMEOUT+1 cycles.
      WAIT_ACK: begin
        if (busy_flag) begin
          state_next = WAIT_DONE;
        end else if (tmo_inc == TMO_BITS'(ACK_TIMEOUT)) begin
          state_next = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!busy_flag) begin
          state_next = (idx == LAST_IDX) ? IDLE : ISSUE;
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  // Sequence index, ack timeout counter, held transfer word and done pulse.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      idx    <= '0;
      tmo    <= '0;
      d_hold <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == WAIT_DONE) && !busy_flag && (idx == LAST_IDX);
      case (state)
        IDLE: begin
          if (pending) idx <= '0;
        end
        ISSUE: begin
          tmo    <= '0;
          d_hold <= word;
        end
        WAIT_ACK: begin
          if (!busy_flag) tmo <= tmo_inc;
        end
        WAIT_DONE: begin
          if (!busy_flag && idx != LAST_IDX) idx <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: the word is presented live during ISSUE and held afterwards.
  always_comb begin
    data_ready = (state == ISSUE);
    active     = (state != IDLE);
    d_out      = (state == ISSUE) ? word : d_hold;
    done       = done_r;
  end

endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer: stimulus pushes expected transfer words,
// a monitor pops and compares on every data_ready strobe.
module tb_lcd_writer;

  localparam int unsigned ACK_TO = 16;

  logic       clock = 1'b0;
  logic       internal_reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh;
  logic       busy_flag;
  logic       busy_force;
  logic       busy_model;
  logic       ack_en;
  logic [8:0] d_out;
  logic       data_ready;
  logic       active;
  logic       done;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  exp_q[$];
  int unsigned cyc = 0;
  int unsigned dr_times[$];
  int          dr_total = 0;
  int          seq_xfers = 0;
  int          done_cnt = 0;
  logic        have_word = 1'b0;
  logic [8:0]  last_word = '0;
  logic [7:0]  model_buf [32];
  int          ack_cnt = 0;

  assign busy_flag = busy_force | busy_model;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  lcd_writer #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .refresh        (refresh),
    .busy_flag      (busy_flag),
    .d_out          (d_out),
    .data_ready     (data_ready),
    .active         (active),
    .done           (done)
  );

  // LCD driver model: busy rises 2 cycles after a strobe, stays up 2 cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (ack_cnt != 0) ack_cnt++;
      else if (data_ready && ack_en) ack_cnt = 1;
      if (ack_cnt == 4) ack_cnt = 0;
      busy_model = (ack_cnt == 2 || ack_cnt == 3);
    end
  end

  // Monitor: scoreboard pops on each strobe, protocol and hold checks.
  initial begin : mon
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (data_ready) begin
        tests++;
        if (busy_flag !== 1'b0) begin
          fails++;
          $display("FAIL strobe_while_busy: busy_flag=%b, required 0", busy_flag);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_transfer: d_out=%h, required no transfer", d_out);
        end else begin
          e = exp_q.pop_front();
          if (d_out !== e) begin
            fails++;
            $display("FAIL transfer[%0d]: d_out=%h, required %h", seq_xfers, d_out, e);
          end
        end
        dr_times.push_back(cyc);
        dr_total++;
        seq_xfers++;
        last_word = d_out;
        have_word = 1'b1;
      end else if (active && have_word) begin
        tests++;
        if (d_out !== last_word) begin
          fails++;
          $display("FAIL d_out_hold: d_out=%h, required %h", d_out, last_word);
        end
      end
      if (done) begin
        done_cnt++;
        tests++;
        if (active !== 1'b0) begin
          fails++;
          $display("FAIL done_with_active: active=%b, required 0", active);
        end
      end
      if (!active) begin
        have_word = 1'b0;
        seq_xfers = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic push_seq();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_buf[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model_buf[i]});
  endtask

  task automatic spaces();
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt < target && n < limit) begin
      tick();
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_xfers(input int target, input int limit);
    int n;
    n = 0;
    while (seq_xfers < target && n < limit) begin
      tick();
      n++;
    end
    check("seq_xfers_reached", seq_xfers, target);
  endtask

  task automatic wait_total(input int target, input int limit);
    int n;
    n = 0;
    while (dr_total < target && n < limit) begin
      tick();
      n++;
    end
    check("strobes_reached", dr_total, target);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    internal_reset = 1'b1;
    busy_force     = 1'b1;
    ack_en         = 1'b1;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_char        = '0;
    refresh        = 1'b0;
    spaces();

    // Reset state, then busy held high: nothing may be strobed.
    repeat (3) tick();
    check("reset_d_out", d_out, 9'h000);
    check("reset_data_ready", data_ready, 0);
    check("reset_active", active, 0);
    check("reset_done", done, 0);
    push_seq();
    internal_reset = 1'b0;
    repeat (1000) tick();
    check("no_strobe_while_busy", dr_total, 0);
    check("active_after_reset", active, 1);
    busy_force = 1'b0;
    wait_done(1, 2000);
    check("blank_seq_len", dr_total, 34);
    check("queue_empty_1", exp_q.size(), 0);

    // Two writes and a refresh back to back: the second write lands on the
    // IDLE clear, so two full sequences run.
    model_buf[0]  = 8'h48;
    model_buf[17] = 8'h69;
    push_seq();
    push_seq();
    wr(5'd0, 8'h48);
    wr(5'd17, 8'h69);
    pulse_refresh();
    wait_done(3, 3000);
    check("queue_empty_2", exp_q.size(), 0);

    // Write at address 3 while idx 10 is in flight.
    push_seq();
    pulse_refresh();
    wait_xfers(11, 500);
    model_buf[3] = 8'h58;
    push_seq();
    wr(5'd3, 8'h58);
    wait_done(5, 3000);
    start = dr_total;
    repeat (300) tick();
    check("no_extra_seq_done", done_cnt, 5);
    check("no_extra_seq_strobes", dr_total, start);
    check("queue_empty_3", exp_q.size(), 0);

    // Refresh pulses while a sequence is active collapse into one more.
    busy_force = 1'b1;
    push_seq();
    push_seq();
    start = dr_total;
    pulse_refresh();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      pulse_refresh();
      tick();
    end
    check("held_in_wait_ready", active, 1);
    check("held_no_strobe", dr_total, start);
    busy_force = 1'b0;
    wait_done(7, 3000);
    repeat (300) tick();
    check("collapse_done", done_cnt, 7);
    check("queue_empty_4", exp_q.size(), 0);

    // No ack: strobe repeats every ACK_TIMEOUT+1 cycles with the same word.
    ack_en = 1'b0;
    start  = dr_total;
    for (int i = 0; i < 4; i++) exp_q.push_back(9'h080);
    push_seq();
    pulse_refresh();
    wait_total(start + 4, 500);
    ack_en = 1'b1;
    n = dr_times.size();
    for (int k = n - 3; k < n; k++) begin
      check("repulse_interval", dr_times[k] - dr_times[k-1], ACK_TO + 1);
    end
    wait_done(8, 3000);
    check("queue_empty_5", exp_q.size(), 0);

    // Reset during WAIT_ACK of idx 20; a write in the reset cycle is ignored.
    push_seq();
    pulse_refresh();
    wait_xfers(21, 500);
    tick();
    internal_reset = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_char = 8'h5A;
    exp_q.delete();
    spaces();
    tick();
    check("midreset_data_ready", data_ready, 0);
    check("midreset_active", active, 0);
    check("midreset_d_out", d_out, 9'h000);
    check("midreset_done", done, 0);
    internal_reset = 1'b0;
    wr_en = 1'b0;
    push_seq();
    wait_done(9, 3000);
    repeat (200) tick();
    check("after_reset_done", done_cnt, 9);
    check("queue_empty_6", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
